idli_sqi_mem_m: RTL



---
 rtl/idli_sqi_mem_m.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/idli_sqi_mem_m.sv
// rtl/idli_sqi_mem_m.sv - single-device quad SQI SRAM responder (READ 0x03 / WRITE 0x02)
module idli_sqi_mem_m #(
  parameter int ADDR_W = 16
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_oe
);

  typedef enum logic [2:0] {
    ST_INSTR,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        sck_q;
  logic        rise, fall;
  logic        rd_flag_q;
  logic [3:0]  instr_hi_q;
  logic [15:0] addr_q;
  logic        ptr_hi_q;
  logic [3:0]  held_q;
  logic        mem_we;
  logic [7:0]  rd_byte;
  logic [7:0]  mem [2**ADDR_W];

  assign rise    = i_mem_sck & ~sck_q;
  assign fall    = ~i_mem_sck & sck_q;
  assign rd_byte = mem[addr_q[ADDR_W-1:0]];
  assign mem_we  = i_mem_rst_n & ~i_mem_cs & rise & (state_q == ST_WR_DATA) & ~ptr_hi_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_mem_cs) begin
      state_d = ST_INSTR;
      cnt_d   = 2'd0;
    end else if (rise) begin
      case (state_q)
        ST_INSTR: begin
          if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d = 2'd0;
            if ({instr_hi_q, i_mem_sio} == 8'h03 || {instr_hi_q, i_mem_sio} == 8'h02)
              state_d = ST_ADDR;
            else
              state_d = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = rd_flag_q ? ST_DUMMY : ST_WR_DATA;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        ST_DUMMY: begin
          if (cnt_q == 2'd1) begin
            cnt_d   = 2'd0;
            state_d = ST_RD_DATA;
          end else begin
            cnt_d = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_mem_gck) begin
    if (!i_mem_rst_n) begin
      state_q <= ST_INSTR;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ptr_hi_q is shared: it selects the held nibble on writes and the driven nibble on reads
  always_ff @(posedge i_mem_gck) begin
    if (!i_mem_rst_n) begin
      sck_q        <= 1'b0;
      ptr_hi_q     <= 1'b1;
      rd_flag_q    <= 1'b0;
      instr_hi_q   <= 4'd0;
      addr_q       <= 16'd0;
      held_q       <= 4'd0;
      o_mem_sio    <= 4'd0;
      o_mem_sio_oe <= 1'b0;
    end else begin
      sck_q <= i_mem_sck;
      if (i_mem_cs) begin
        o_mem_sio_oe <= 1'b0;
        ptr_hi_q     <= 1'b1;
      end else begin
        if (rise) begin
          case (state_q)
            ST_INSTR: begin
              if (cnt_q == 2'd0)
                instr_hi_q <= i_mem_sio;
              else
                rd_flag_q <= ({instr_hi_q, i_mem_sio} == 8'h03);
            end
            ST_ADDR: begin
              addr_q <= {addr_q[11:0], i_mem_sio};
              if (cnt_q == 2'd3)
                ptr_hi_q <= 1'b1;
            end
            ST_DUMMY: begin
              if (cnt_q == 2'd1)
                ptr_hi_q <= 1'b1;
            end
            ST_WR_DATA: begin
              if (ptr_hi_q) begin
                held_q   <= i_mem_sio;
                ptr_hi_q <= 1'b0;
              end else begin
                ptr_hi_q <= 1'b1;
                addr_q   <= addr_q + 16'd1;
              end
            end
            default: ;
          endcase
        end
        if (fall && state_q == ST_RD_DATA) begin
          o_mem_sio_oe <= 1'b1;
          o_mem_sio    <= ptr_hi_q ? rd_byte[7:4] : rd_byte[3:0];
          ptr_hi_q     <= ~ptr_hi_q;
          if (!ptr_hi_q)
            addr_q <= addr_q + 16'd1;
        end
      end
    end
  end

  // Storage is deliberately outside reset so contents survive i_mem_rst_n
  always_ff @(posedge i_mem_gck) begin
    if (mem_we)
      mem[addr_q[ADDR_W-1:0]] <= {held_q, i_mem_sio};
  end

endmodule
